descrambler_sync_8bit: RTL and testbench



---
 rtl/descrambler_pkg.sv | 23 ++
 rtl/descrambler_sync_8bit_if.sv | 26 ++
 rtl/lfsr_step8.sv | 24 ++
 rtl/descrambler_sync_8bit.sv | 146 ++++++++++++++
 tb/tb_descrambler_sync_8bit.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/descrambler_pkg.sv
// Shared constants for the receive-side 8-bit descrambler:
// K-symbol codes, LFSR seed/mask, FSM state encodings.
package descrambler_pkg;

    localparam logic [7:0]  K_COM     = 8'hBC;
    localparam logic [7:0]  K_SKP     = 8'h1C;
    localparam logic [15:0] LFSR_SEED = 16'hFFFF;
    localparam logic [15:0] LFSR_MASK = 16'h0039;

    localparam logic [0:0] UNLOCKED = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;

    function automatic logic is_legal_k(input logic [7:0] s);
        logic r;
        case (s)
            8'hBC, 8'h1C, 8'hF7, 8'hFB,
            8'hFD, 8'hFE, 8'h5C, 8'h7C: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/descrambler_sync_8bit_if.sv
// Symbol bus between the link receiver and the descrambler.
// slave = descrambler side, master = upstream/consumer side.
interface descrambler_sync_8bit_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 valid_in;
    logic [7:0]           din;
    logic                 k_in;
    logic                 dis_scrambler_in;
    logic                 valid_out;
    logic [7:0]           dout;
    logic                 k_out;
    logic                 locked;
    logic                 com_det;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport slave (
        input  valid_in, din, k_in, dis_scrambler_in,
        output valid_out, dout, k_out, locked, com_det, err_cnt
    );

    modport master (
        output valid_in, din, k_in, dis_scrambler_in,
        input  valid_out, dout, k_out, locked, com_det, err_cnt
    );
endinterface

// File: rtl/lfsr_step8.sv
// Eight Galois LFSR bit-steps, LSB first, G(x)=x^16+x^5+x^4+x^3+1.
// Returns the advanced LFSR and din XORed with the keystream.
module lfsr_step8
    import descrambler_pkg::*;
(
    input  logic [15:0] i_lfsr,
    input  logic [7:0]  i_din,
    output logic [15:0] o_lfsr,
    output logic [7:0]  o_dout
);

    logic [15:0] w_l;

    always_comb begin
        w_l    = i_lfsr;
        o_dout = '0;
        for (int i = 0; i < 8; i++) begin
            o_dout[i] = i_din[i] ^ w_l[15];
            w_l = {w_l[14:0], 1'b0} ^ (w_l[15] ? LFSR_MASK : 16'h0000);
        end
        o_lfsr = w_l;
    end

endmodule

// File: rtl/descrambler_sync_8bit.sv
// Receive-side additive descrambler with COM-based symbol lock.
// Define DESCRAMBLER_LOCK_TIMEOUT_EN to drop lock after MAX_COM_GAP symbols without COM.
module descrambler_sync_8bit
    import descrambler_pkg::*;
#(
    parameter int MAX_COM_GAP = 1024,
    parameter int ERR_LIMIT   = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_b,
    descrambler_sync_8bit_if.slave bus
);

    localparam int RUN_W = $clog2(ERR_LIMIT + 1);

    if (MAX_COM_GAP < 1 || ERR_LIMIT < 1) begin : g_bad_param
        $error("MAX_COM_GAP and ERR_LIMIT must be >= 1");
    end

    logic [15:0]          r_lfsr;
    logic [0:0]           r_state;
    logic [RUN_W-1:0]     r_err_run;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_valid_out;
    logic [7:0]           r_dout;
    logic                 r_k_out;
    logic                 r_locked;
    logic                 r_com_det;

    logic [15:0]      w_lfsr_step;
    logic [7:0]       w_desc;
    logic [15:0]      w_lfsr_d;
    logic [7:0]       w_dout_d;
    logic [0:0]       w_state_d;
    logic             w_is_com;
    logic             w_is_skp;
    logic             w_illegal;
    logic             w_locked;
    logic [RUN_W-1:0] w_err_run_inc;
    logic             w_err_trip;
    logic             w_gap_trip;

    lfsr_step8 u_step (
        .i_lfsr (r_lfsr),
        .i_din  (bus.din),
        .o_lfsr (w_lfsr_step),
        .o_dout (w_desc)
    );

    assign w_is_com      = bus.k_in && (bus.din == K_COM);
    assign w_is_skp      = bus.k_in && (bus.din == K_SKP);
    assign w_illegal     = bus.k_in && !is_legal_k(bus.din);
    assign w_locked      = (r_state == LOCKED);
    assign w_err_run_inc = r_err_run + 1'b1;
    assign w_err_trip    = w_locked && w_illegal &&
                           (w_err_run_inc == RUN_W'(ERR_LIMIT));

`ifdef DESCRAMBLER_LOCK_TIMEOUT_EN
    localparam int GAP_W = $clog2(MAX_COM_GAP + 1);

    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_inc;

    assign w_gap_inc  = r_gap + 1'b1;
    assign w_gap_trip = w_locked && !w_is_com &&
                        (w_gap_inc == GAP_W'(MAX_COM_GAP));

    // Gap counts valid non-COM symbols while locked; COM always wins.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_gap <= '0;
        end else if (bus.valid_in) begin
            if (w_is_com || !w_locked || w_gap_trip)
                r_gap <= '0;
            else
                r_gap <= w_gap_inc;
        end
    end
`else
    assign w_gap_trip = 1'b0;
`endif

    always_comb begin
        w_lfsr_d = w_lfsr_step;
        unique case (1'b1)
            w_is_com: w_lfsr_d = LFSR_SEED;
            w_is_skp: w_lfsr_d = r_lfsr;
            default:  w_lfsr_d = w_lfsr_step;
        endcase
    end

    always_comb begin
        w_dout_d = w_desc;
        if (bus.k_in || bus.dis_scrambler_in)
            w_dout_d = bus.din;
    end

    always_comb begin
        w_state_d = r_state;
        if (w_is_com)
            w_state_d = LOCKED;
        else if (w_err_trip || w_gap_trip)
            w_state_d = UNLOCKED;
    end

    // locked tracks the state the symbol was received in, so it falls
    // one output after the symbol that caused loss of lock.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_lfsr      <= LFSR_SEED;
            r_state     <= UNLOCKED;
            r_err_run   <= '0;
            r_err_cnt   <= '0;
            r_valid_out <= 1'b0;
            r_dout      <= '0;
            r_k_out     <= 1'b0;
            r_locked    <= 1'b0;
            r_com_det   <= 1'b0;
        end else begin
            r_valid_out <= bus.valid_in && (w_locked || w_is_com);
            r_com_det   <= bus.valid_in && w_is_com;
            r_locked    <= w_locked || (bus.valid_in && w_is_com);
            if (bus.valid_in) begin
                r_dout  <= w_dout_d;
                r_k_out <= bus.k_in;
                r_lfsr  <= w_lfsr_d;
                r_state <= w_state_d;
                if (w_locked && w_illegal && !w_err_trip)
                    r_err_run <= w_err_run_inc;
                else
                    r_err_run <= '0;
                if (w_illegal && (r_err_cnt != '1))
                    r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign bus.valid_out = r_valid_out;
    assign bus.dout      = r_dout;
    assign bus.k_out     = r_k_out;
    assign bus.locked    = r_locked;
    assign bus.com_det   = r_com_det;
    assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_descrambler_sync_8bit.sv
// Directed bench for descrambler_sync_8bit (MAX_COM_GAP=16, ERR_LIMIT=4).
module tb_descrambler_sync_8bit;

    logic clk = 1'b0;
    logic rst_b;
    int   n_vec = 0;
    int   n_err = 0;

    logic [7:0] ref_seq [8] = '{8'hFF, 8'h17, 8'hC0, 8'h14,
                                8'hB2, 8'hE7, 8'h02, 8'h82};

    descrambler_sync_8bit_if #(.ERR_CNT_W(8)) bus ();

    descrambler_sync_8bit #(
        .MAX_COM_GAP (16),
        .ERR_LIMIT   (4),
        .ERR_CNT_W   (8)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, required finish before 200us");
        $fatal(1);
    end

    function automatic logic [23:0] scr(input logic [15:0] l, input logic [7:0] d);
        logic [15:0] x;
        logic [7:0]  o;
        x = l;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            o[i] = d[i] ^ x[15];
            x = {x[14:0], 1'b0} ^ (x[15] ? 16'h0039 : 16'h0000);
        end
        return {x, o};
    endfunction

    task automatic sym(input logic [7:0] d, input logic k, input logic dis);
        @(negedge clk);
        bus.valid_in         = 1'b1;
        bus.din              = d;
        bus.k_in             = k;
        bus.dis_scrambler_in = dis;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.valid_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b                = 1'b0;
        bus.valid_in         = 1'b0;
        bus.din              = '0;
        bus.k_in             = 1'b0;
        bus.dis_scrambler_in = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({bus.valid_out, bus.dout, bus.k_out, bus.locked, bus.com_det, bus.err_cnt} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {bus.valid_out, bus.dout, bus.k_out, bus.locked, bus.com_det, bus.err_cnt});
        end
        sym(8'h00, 1'b0, 1'b0);
        n_vec++;
        if (bus.valid_out !== 1'b0 || bus.locked !== 1'b0) begin
            n_err++;
            $display("FAIL pre_com_data: valid_out=%b locked=%b, required 0 0",
                     bus.valid_out, bus.locked);
        end
        idle();
    endtask

    task automatic test_lock();
        do_reset();
        sym(8'hBC, 1'b1, 1'b0);
        n_vec++;
        if ({bus.valid_out, bus.dout, bus.k_out, bus.locked, bus.com_det} !== {1'b1, 8'hBC, 3'b111}) begin
            n_err++;
            $display("FAIL lock_com: v=%b d=%h k=%b l=%b c=%b, required 1 bc 1 1 1",
                     bus.valid_out, bus.dout, bus.k_out, bus.locked, bus.com_det);
        end
        for (int i = 0; i < 8; i++) begin
            sym(ref_seq[i], 1'b0, 1'b0);
            n_vec++;
            if ({bus.valid_out, bus.dout, bus.k_out, bus.locked, bus.com_det} !== {1'b1, 8'h00, 3'b010}) begin
                n_err++;
                $display("FAIL lock_data[%0d]: v=%b d=%h k=%b l=%b c=%b, required 1 00 0 1 0",
                         i, bus.valid_out, bus.dout, bus.k_out, bus.locked, bus.com_det);
            end
        end
        idle();
    endtask

    task automatic test_skp();
        do_reset();
        sym(8'hBC, 1'b1, 1'b0);
        sym(8'hFF, 1'b0, 1'b0);
        n_vec++;
        if (bus.dout !== 8'h00) begin
            n_err++;
            $display("FAIL skp_pre: dout=%h, required 00", bus.dout);
        end
        sym(8'h1C, 1'b1, 1'b0);
        n_vec++;
        if ({bus.valid_out, bus.dout, bus.k_out, bus.com_det} !== {1'b1, 8'h1C, 2'b10}) begin
            n_err++;
            $display("FAIL skp_sym: v=%b d=%h k=%b c=%b, required 1 1c 1 0",
                     bus.valid_out, bus.dout, bus.k_out, bus.com_det);
        end
        sym(8'h17, 1'b0, 1'b0);
        n_vec++;
        if (bus.dout !== 8'h00 || bus.k_out !== 1'b0) begin
            n_err++;
            $display("FAIL skp_post: dout=%h k=%b, required 00 0", bus.dout, bus.k_out);
        end
        idle();
    endtask

    task automatic test_dis();
        do_reset();
        sym(8'hBC, 1'b1, 1'b0);
        sym(8'hFF, 1'b0, 1'b0);
        sym(8'h5A, 1'b0, 1'b1);
        n_vec++;
        if (bus.dout !== 8'h5A || bus.valid_out !== 1'b1) begin
            n_err++;
            $display("FAIL dis_bypass: dout=%h v=%b, required 5a 1", bus.dout, bus.valid_out);
        end
        sym(8'hC0, 1'b0, 1'b0);
        n_vec++;
        if (bus.dout !== 8'h00) begin
            n_err++;
            $display("FAIL dis_advance: dout=%h, required 00", bus.dout);
        end
        idle();
    endtask

    task automatic test_errors();
        do_reset();
        sym(8'hBC, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sym(8'h00, 1'b1, 1'b0);
            n_vec++;
            if ({bus.valid_out, bus.k_out, bus.locked} !== 3'b111 || bus.err_cnt !== 8'(i + 1)) begin
                n_err++;
                $display("FAIL err_sym[%0d]: v=%b k=%b l=%b cnt=%0d, required 1 1 1 %0d",
                         i, bus.valid_out, bus.k_out, bus.locked, bus.err_cnt, i + 1);
            end
        end
        sym(8'hFF, 1'b0, 1'b0);
        n_vec++;
        if (bus.valid_out !== 1'b0 || bus.locked !== 1'b0) begin
            n_err++;
            $display("FAIL err_unlock: v=%b l=%b, required 0 0", bus.valid_out, bus.locked);
        end
        sym(8'hBC, 1'b1, 1'b0);
        n_vec++;
        if ({bus.valid_out, bus.locked, bus.com_det} !== 3'b111 || bus.err_cnt !== 8'd4) begin
            n_err++;
            $display("FAIL err_relock: v=%b l=%b c=%b cnt=%0d, required 1 1 1 4",
                     bus.valid_out, bus.locked, bus.com_det, bus.err_cnt);
        end
        sym(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) sym(8'h00, 1'b1, 1'b0);
        sym(8'hB2, 1'b0, 1'b0);
        n_vec++;
        if (bus.dout !== 8'h00 || bus.locked !== 1'b1) begin
            n_err++;
            $display("FAIL err_k_advance: dout=%h l=%b, required 00 1", bus.dout, bus.locked);
        end
        for (int i = 0; i < 3; i++) sym(8'h00, 1'b1, 1'b0);
        idle();
        n_vec++;
        if (bus.locked !== 1'b1 || bus.err_cnt !== 8'd10) begin
            n_err++;
            $display("FAIL err_run_clear: l=%b cnt=%0d, required 1 10", bus.locked, bus.err_cnt);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 260; i++) sym(8'h00, 1'b1, 1'b0);
        n_vec++;
        if (bus.err_cnt !== 8'hFF || bus.valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL err_saturate: cnt=%h v=%b, required ff 0", bus.err_cnt, bus.valid_out);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        sym(8'hBC, 1'b1, 1'b0);
        sym(8'h00, 1'b1, 1'b0);
        #1;
        rst_b = 1'b0;
        #1;
        n_vec++;
        if ({bus.valid_out, bus.dout, bus.k_out, bus.locked, bus.com_det, bus.err_cnt} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_mid: got %h, required 0",
                     {bus.valid_out, bus.dout, bus.k_out, bus.locked, bus.com_det, bus.err_cnt});
        end
        @(negedge clk);
        bus.valid_in = 1'b0;
        rst_b = 1'b1;
    endtask

    task automatic test_gap();
        logic [15:0] l;
        logic [23:0] r;
        do_reset();
        sym(8'hBC, 1'b1, 1'b0);
        l = 16'hFFFF;
`ifdef DESCRAMBLER_LOCK_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            r = scr(l, 8'h00);
            l = r[23:8];
            sym(r[7:0], 1'b0, 1'b0);
            n_vec++;
            if (bus.valid_out !== 1'b1 || bus.dout !== 8'h00 || bus.locked !== 1'b1) begin
                n_err++;
                $display("FAIL gap_data[%0d]: v=%b d=%h l=%b, required 1 00 1",
                         i, bus.valid_out, bus.dout, bus.locked);
            end
        end
        idle();
        n_vec++;
        if (bus.locked !== 1'b0) begin
            n_err++;
            $display("FAIL gap_timeout: locked=%b, required 0", bus.locked);
        end
`else
        for (int i = 0; i < 20; i++) begin
            r = scr(l, 8'h00);
            l = r[23:8];
            sym(r[7:0], 1'b0, 1'b0);
        end
        n_vec++;
        if (bus.valid_out !== 1'b1 || bus.dout !== 8'h00 || bus.locked !== 1'b1) begin
            n_err++;
            $display("FAIL gap_no_timeout: v=%b d=%h l=%b, required 1 00 1",
                     bus.valid_out, bus.dout, bus.locked);
        end
`endif
        idle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] l;
        logic [23:0] r;
        logic [7:0]  src;
        logic [7:0]  tx;
        logic        k;
        int          bad;
        do_reset();
        l   = 16'hFFFF;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            k = 1'b1;
            if (i % 12 == 0) begin
                src = 8'hBC;
                tx  = 8'hBC;
                l   = 16'hFFFF;
            end else if (i % 12 == 6) begin
                src = 8'h1C;
                tx  = 8'h1C;
            end else begin
                k   = 1'b0;
                src = 8'($urandom_range(0, 255));
                r   = scr(l, src);
                l   = r[23:8];
                tx  = r[7:0];
            end
            sym(tx, k, 1'b0);
            n_vec++;
            if (bus.valid_out !== 1'b1 || bus.dout !== src || bus.k_out !== k) begin
                n_err++;
                if (bad < 5)
                    $display("FAIL loopback[%0d]: v=%b d=%h k=%b, required 1 %h %b",
                             i, bus.valid_out, bus.dout, bus.k_out, src, k);
                bad++;
            end
        end
        idle();
    endtask

    initial begin
        rst_b                = 1'b0;
        bus.valid_in         = 1'b0;
        bus.din              = '0;
        bus.k_in             = 1'b0;
        bus.dis_scrambler_in = 1'b0;
        test_reset();
        test_lock();
        test_skp();
        test_dis();
        test_errors();
        test_saturate();
        test_reset_mid();
        test_gap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
